// File: rtl/sdram_lfsr_tester.sv
// sdram_lfsr_tester: repeated fill/verify passes over SDRAM using a 32-bit Galois LFSR data stream
module sdram_lfsr_tester #(
  parameter int ADDR_BITS = 24,
  parameter logic [31:0] SEED = 32'hACE12345
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  output logic                 req,
  output logic                 we,
  output logic [ADDR_BITS-1:0] addr,
  output logic [15:0]          wdata,
  input  logic                 ack,
  input  logic [15:0]          rdata,
  output logic                 busy,
  output logic [15:0]          pass_count,
  output logic [15:0]          err_count,
  output logic [ADDR_BITS-1:0] first_err_addr
);
  localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, VERIFY = 2'd2;
  logic [1:0] state;
  logic [31:0] lfsr, pass_seed, lfsr_nx;
  logic stop_pend, done, last, miss, halt;
  assign lfsr_nx = (lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 32'h0);
  assign done = req & ack;
  assign last = &addr;
  assign miss = state == VERIFY && rdata != lfsr[15:0];
  assign halt = stop | stop_pend;
  assign we = state == FILL;
  assign wdata = we ? lfsr[15:0] : 16'h0;
  assign busy = state != IDLE;
  // access sequencing: one request at a time, one idle cycle after each ack, stop honoured between accesses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      req <= 1'b0;
      addr <= '0;
      lfsr <= SEED;
      pass_seed <= SEED;
      pass_count <= 16'd0;
      err_count <= 16'd0;
      first_err_addr <= '0;
      stop_pend <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= FILL;
        req <= 1'b1;
        addr <= '0;
        lfsr <= SEED;
        pass_seed <= SEED;
        err_count <= 16'd0;
        first_err_addr <= '0;
        stop_pend <= 1'b0;
      end
    end else if (done) begin
      req <= 1'b0;
      addr <= addr + ADDR_BITS'(1);
      lfsr <= (last && state == FILL) ? pass_seed : lfsr_nx;
      if (miss) begin
        err_count <= err_count + {15'd0, ~&err_count};
        if (err_count == '0) first_err_addr <= addr;
      end
      if (last && state == VERIFY) begin
        pass_count <= pass_count + 16'd1;
        pass_seed <= lfsr_nx;
      end
      state <= halt ? IDLE : last ? (state == FILL ? VERIFY : FILL) : state;
      stop_pend <= 1'b0;
    end else if (req) begin
      stop_pend <= halt;
    end else begin
      state <= halt ? IDLE : state;
      req <= ~halt;
      stop_pend <= 1'b0;
    end
endmodule

// File: tb/tb_sdram_lfsr_tester.sv
// tb_sdram_lfsr_tester: randomized scoreboard bench with a memory/controller model for sdram_lfsr_tester
module tb_sdram_lfsr_tester;
  localparam int AB = 4;
  localparam logic [31:0] SEED = 32'hACE12345;
  logic clk = 0, reset = 1, start = 0, stop = 0, ack = 0;
  logic [15:0] rdata = 0;
  logic req, we, busy;
  logic [AB-1:0] addr, first_err_addr;
  logic [15:0] wdata, pass_count, err_count;
  typedef struct packed {logic w; logic [AB-1:0] a; logic [15:0] d;} acc_t;
  acc_t exp_q[$];
  logic [31:0] stream [0:127];
  logic [15:0] mem [0:15];
  logic [15:0] corrupt = 0;
  int tests = 0, fails = 0, done_n = 0, exp_pass = 0;
  bit hold = 0, man_ack = 0;

  sdram_lfsr_tester #(.ADDR_BITS(AB), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .busy(busy), .pass_count(pass_count),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // n accesses are allowed, then stop is raised either with access n outstanding or in the gap after it
  task automatic run(input int n, input logic [15:0] cmask, input bit do_force, input bit gap);
    int base, cyc, e_err;
    logic [AB-1:0] e_first;
    bit hit, forced;
    acc_t e;
    corrupt = cmask;
    e_err = do_force ? 32'hFFFE : 0;
    e_first = '0;
    for (int k = 0; k < n; k++) begin
      int p, w, a;
      p = k / 32;
      w = k % 32;
      a = w % 16;
      e.w = w < 16;
      e.a = AB'(a);
      e.d = (k == 0) ? 16'h2345 : stream[16 * p + a][15:0];
      exp_q.push_back(e);
      if (w >= 16 && cmask[a]) begin
        if (e_err == 0) e_first = AB'(a);
        if (e_err < 32'hFFFF) e_err++;
      end
    end
    exp_pass = (exp_pass + n / 32) % 65536;
    base = done_n;
    start = 1;
    tick;
    start = 0;
    cyc = 0;
    hit = 0;
    forced = 0;
    while (!hit && cyc < 3000) begin
      tick;
      cyc++;
      if (do_force && !forced && done_n - base >= 2) begin
        force dut.err_count = 16'hFFFE;
        tick;
        release dut.err_count;
        forced = 1;
      end
      hit = gap ? (done_n - base == n && !req && busy) : (done_n - base == n - 1 && req && !ack);
    end
    chk("stop_point_reached", {31'd0, hit}, 1);
    stop = 1;
    cyc = 0;
    while (busy && cyc < 50) begin
      tick;
      cyc++;
    end
    stop = 0;
    tick;
    chk("busy_after_stop", {31'd0, busy}, 0);
    chk("req_after_stop", {31'd0, req}, 0);
    chk("access_count", done_n - base, n);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("err_count", {16'd0, err_count}, e_err);
    chk("first_err_addr", {28'd0, first_err_addr}, {28'd0, e_first});
    chk("pass_count", {16'd0, pass_count}, exp_pass);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    acc_t e;
    stream[0] = SEED;
    for (int i = 1; i < 128; i++) stream[i] = step(stream[i - 1]);
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    fork
      begin : monitor
        acc_t m;
        logic rq;
        logic [AB-1:0] ra;
        logic [15:0] rd;
        rq = 0;
        ra = '0;
        rd = '0;
        forever begin
          @(negedge clk);
          if (reset) rq = 0;
          else begin
            if (req && !rq) begin
              if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_access: got addr %0h we %0b expected none", addr, we);
              end else begin
                m = exp_q.pop_front();
                chk("acc_we", {31'd0, we}, {31'd0, m.w});
                chk("acc_addr", {28'd0, addr}, {28'd0, m.a});
                if (m.w) chk("acc_wdata", {16'd0, wdata}, {16'd0, m.d});
              end
            end else if (req) begin
              chk("hold_addr", {28'd0, addr}, {28'd0, ra});
              chk("hold_wdata", {16'd0, wdata}, {16'd0, rd});
            end
            if (req && ack) done_n++;
            rq = req;
            ra = addr;
            rd = wdata;
          end
        end
      end
      begin : controller
        int wc, lat;
        wc = 0;
        lat = 3;
        forever begin
          @(posedge clk);
          #1;
          ack = 0;
          if (man_ack) ack = 1;
          else if (req && !hold && !reset) begin
            wc++;
            if (wc >= lat) begin
              ack = 1;
              rdata = mem[addr] ^ {15'd0, corrupt[addr]};
              if (we) mem[addr] = wdata;
              wc = 0;
              lat = $urandom_range(2, 4);
            end
          end else wc = 0;
        end
      end
    join_none
    repeat (3) tick;
    chk("rst_req", {31'd0, req}, 0);
    chk("rst_we", {31'd0, we}, 0);
    chk("rst_addr", {28'd0, addr}, 0);
    chk("rst_wdata", {16'd0, wdata}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_pass", {16'd0, pass_count}, 0);
    chk("rst_err", {16'd0, err_count}, 0);
    chk("rst_first", {28'd0, first_err_addr}, 0);
    reset = 0;
    tick;
    run(5, 16'h0, 0, 0);
    run(3, 16'h0, 0, 1);
    run(64, 16'h0, 0, 0);
    run(32, 16'h0220, 0, 0);
    for (int r = 0; r < 5; r++) run($urandom_range(1, 80), 16'($urandom), 0, 1'($urandom_range(0, 1)));
    run(32, 16'h0007, 1, 0);
    hold = 1;
    e.w = 1;
    e.a = '0;
    e.d = 16'h2345;
    exp_q.push_back(e);
    start = 1;
    tick;
    start = 0;
    repeat (3) tick;
    chk("req_before_reset", {31'd0, req}, 1);
    reset = 1;
    tick;
    chk("req_in_reset", {31'd0, req}, 0);
    reset = 0;
    tick;
    man_ack = 1;
    tick;
    man_ack = 0;
    repeat (3) tick;
    chk("post_rst_req", {31'd0, req}, 0);
    chk("post_rst_busy", {31'd0, busy}, 0);
    chk("post_rst_addr", {28'd0, addr}, 0);
    chk("post_rst_wdata", {16'd0, wdata}, 0);
    chk("post_rst_pass", {16'd0, pass_count}, 0);
    chk("post_rst_err", {16'd0, err_count}, 0);
    chk("post_rst_first", {28'd0, first_err_addr}, 0);
    exp_q.delete();
    exp_pass = 0;
    hold = 0;
    cyc = 0;
    run(2, 16'h0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
